// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the EX-stage ALU control decoder and the multiply/divide sequencer.
// ALU_CTRL_DIV_EN (see alu_ctrl_seq.sv) controls whether the divide group is legal.
package alu_ctrl_pkg;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_seq.sv
// Multiply/divide sequencer: IDLE/RUN/DONE FSM with a down-counter.
// Handshake: start_o pulses in the accepting IDLE cycle, done_o pulses in DONE; stall_o covers LAT cycles.
module mdu_seq
    import alu_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 33,
    parameter int CNT_W   = 6
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_i,
    input  logic       flush_i,
    input  logic [2:0] funct3_i,
    output logic       start_o,
    output logic [2:0] op_o,
    output logic       stall_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] load_val;

    assign load_val = funct3_i[2] ? DIV_LD : MUL_LD;
    assign op_o     = op_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        start_o = 1'b0;
        stall_o = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_i && !flush_i) begin
                    start_o = 1'b1;
                    stall_o = 1'b1;
                    op_d    = funct3_i;
                    cnt_d   = load_val;
                    // A one-cycle latency has no RUN phase at all.
                    state_d = (load_val == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                stall_o = 1'b1;
                busy_o  = 1'b1;
                if (flush_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= 3'b000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// EX-stage ALU control: combinational RV32I/RV32M decode plus the MDU sequencer.
// Define ALU_CTRL_DIV_EN to make div/divu/rem/remu legal; otherwise they decode as illegal.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W  = 5,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 33,
    parameter int CNT_W   = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic [1:0]        aluop_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    output logic [CTRL_W-1:0] aluctr_o,
    output logic              mdu_start_o,
    output logic [2:0]        mdu_op_o,
    output logic              stall_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              illegal_o
);

`ifdef ALU_CTRL_DIV_EN
    localparam logic DIV_EN = 1'b1;
`else
    localparam logic DIV_EN = 1'b0;
`endif

    logic [3:0] code;
    logic       mdu_sel;
    logic       illegal;

    // The base R/I encodings line up with {0,funct3}; the alternate forms set bit 3.
    always_comb begin
        code    = ALU_ADD;
        mdu_sel = 1'b0;
        illegal = 1'b0;
        case (aluop_i)
            ALUOP_MEM:    code = ALU_ADD;
            ALUOP_BRANCH: code = ALU_SUB;
            ALUOP_RTYPE: begin
                if (funct7_i == FUNCT7_BASE) begin
                    code = {1'b0, funct3_i};
                end else if (funct7_i == FUNCT7_ALT && funct3_i == 3'b000) begin
                    code = ALU_SUB;
                end else if (funct7_i == FUNCT7_ALT && funct3_i == 3'b101) begin
                    code = ALU_SRA;
                end else if (funct7_i == FUNCT7_MULDIV && (!funct3_i[2] || DIV_EN)) begin
                    code    = {1'b0, funct3_i};
                    mdu_sel = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            ALUOP_ITYPE: begin
                if (funct3_i == 3'b001 && funct7_i != FUNCT7_BASE) begin
                    illegal = 1'b1;
                end else if (funct3_i == 3'b101) begin
                    code = funct7_i[5] ? ALU_SRA : ALU_SRL;
                end else begin
                    code = {1'b0, funct3_i};
                end
            end
            default: code = ALU_ADD;
        endcase
    end

    assign aluctr_o  = CTRL_W'({mdu_sel, code});
    assign illegal_o = illegal;

    mdu_seq #(
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT),
        .CNT_W  (CNT_W)
    ) u_mdu_seq (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (valid_i && mdu_sel),
        .flush_i (flush_i),
        .funct3_i(funct3_i),
        .start_o (mdu_start_o),
        .op_o    (mdu_op_o),
        .stall_o (stall_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: directed cases with literal expectations,
// then randomized traffic compared every cycle against an operation-level model.
module tb_alu_ctrl_seq;

`ifdef ALU_CTRL_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 33;

    logic       clk = 1'b0;
    logic       rst, valid, flush;
    logic [1:0] aluop;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] aluctr;
    logic       mdu_start, stall, busy, done, illegal;
    logic [2:0] mdu_op;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // clock / reset
    always #5 clk = ~clk;

    alu_ctrl_seq #(.CTRL_W(5), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .flush_i(flush),
        .aluop_i(aluop), .funct3_i(funct3), .funct7_i(funct7),
        .aluctr_o(aluctr), .mdu_start_o(mdu_start), .mdu_op_o(mdu_op),
        .stall_o(stall), .busy_o(busy), .done_o(done), .illegal_o(illegal)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode, written from the instruction semantics.
    function automatic logic [5:0] ref_decode(input logic [1:0] op, input logic [2:0] f3,
                                              input logic [6:0] f7);
        logic [4:0] c;
        logic       ill;
        c = 5'b00000;
        ill = 1'b0;
        if (op == 2'b01) c = 5'b01000;
        else if (op == 2'b10) begin
            if (f7 == 7'd0) c = {2'b00, f3};
            else if (f7 == 7'h20 && f3 == 3'd0) c = 5'b01000;
            else if (f7 == 7'h20 && f3 == 3'd5) c = 5'b01101;
            else if (f7 == 7'h01 && (f3 < 3'd4 || DIV_EN)) c = 5'b10000 + {2'b00, f3};
            else ill = 1'b1;
        end else if (op == 2'b11) begin
            if (f3 == 3'd1 && f7 != 7'd0) ill = 1'b1;
            else if (f3 == 3'd5) c = f7[5] ? 5'b01101 : 5'b00101;
            else c = {2'b00, f3};
        end
        return {ill, c};
    endfunction

    // Operation model: an active op is in its k-th cycle after the start cycle.
    bit         m_act = 1'b0;
    int         m_k = 0;
    int         m_lat = 0;
    logic [2:0] m_op = 3'b000;

    function automatic bit model_start();
        logic [5:0] d;
        d = ref_decode(aluop, funct3, funct7);
        return !m_act && valid && d[4] && !flush;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_act <= 1'b0;
            m_op  <= 3'b000;
        end else if (!m_act) begin
            if (model_start()) begin
                m_act <= 1'b1;
                m_k   <= 1;
                m_lat <= funct3[2] ? DIV_LAT : MUL_LAT;
                m_op  <= funct3;
            end
        end else if (flush || m_k == m_lat) begin
            m_act <= 1'b0;
        end else begin
            m_k <= m_k + 1;
        end
    end

    // scoreboard: compare every cycle once reset has been applied
    always @(negedge clk) begin
        if (chk_en) begin
            logic [5:0] d;
            logic [31:0] exp_stall;
            d = ref_decode(aluop, funct3, funct7);
            exp_stall = m_act ? 32'(m_k < m_lat) : 32'(model_start());
            check("aluctr", 32'(aluctr), 32'(d[4:0]));
            check("illegal", 32'(illegal), 32'(d[5]));
            check("start", 32'(mdu_start), 32'(model_start()));
            check("stall", 32'(stall), exp_stall);
            check("busy", 32'(busy), 32'(m_act));
            check("done", 32'(done), 32'(m_act && m_k == m_lat));
            check("mdu_op", 32'(mdu_op), 32'(m_op));
        end
    end

    // driver tasks
    task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic fl);
        valid = v; aluop = op; funct3 = f3; funct7 = f7; flush = fl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    int s0, s1, cyc, dcyc;

    initial begin
        rst = 1'b1;
        drive(1'b0, 2'b00, 3'd0, 7'd0, 1'b0);
        next_cycle();
        chk_en = 1'b1;
        mid();
        check("rst_busy", 32'(busy), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_done", 32'(done), 0);
        check("rst_mdu_op", 32'(mdu_op), 0);
        next_cycle();
        rst = 1'b0;

        // R-type and I-type decode
        drive(1'b1, 2'b10, 3'd0, 7'h20, 1'b0); mid();
        check("sub", 32'(aluctr), 32'b01000);
        check("sub_ill", 32'(illegal), 0);
        next_cycle(); drive(1'b1, 2'b10, 3'd5, 7'h20, 1'b0); mid();
        check("sra", 32'(aluctr), 32'b01101);
        next_cycle(); drive(1'b1, 2'b10, 3'd6, 7'h00, 1'b0); mid();
        check("or", 32'(aluctr), 32'b00110);
        next_cycle(); drive(1'b1, 2'b11, 3'd1, 7'h20, 1'b0); mid();
        check("slli_bad_ill", 32'(illegal), 1);
        check("slli_bad_code", 32'(aluctr), 0);
        check("slli_bad_start", 32'(mdu_start), 0);

        // mul timing
        next_cycle(); drive(1'b1, 2'b10, 3'd0, 7'h01, 1'b0); mid();
        check("mul_c0_start", 32'(mdu_start), 1);
        check("mul_c0_stall", 32'(stall), 1);
        for (int i = 1; i < MUL_LAT; i++) begin
            next_cycle(); mid();
            check("mul_run_stall", 32'(stall), 1);
            check("mul_run_start", 32'(mdu_start), 0);
        end
        next_cycle(); mid();
        check("mul_done", 32'(done), 1);
        check("mul_done_stall", 32'(stall), 0);
        next_cycle(); drive(1'b0, 2'b00, 3'd0, 7'd0, 1'b0); mid();
        check("mul_idle_busy", 32'(busy), 0);

        // div
        next_cycle(); drive(1'b1, 2'b10, 3'd4, 7'h01, 1'b0); mid();
        if (DIV_EN) begin
            dcyc = 0;
            for (int i = 0; i < 40 && !done; i++) begin
                if (stall) dcyc++;
                next_cycle(); mid();
            end
            check("div_stall_cycles", 32'(dcyc), 33);
            check("div_done", 32'(done), 1);
            check("div_op", 32'(mdu_op), 32'b100);
        end else begin
            check("div_ill", 32'(illegal), 1);
            check("div_stall", 32'(stall), 0);
            check("div_start", 32'(mdu_start), 0);
        end
        next_cycle(); drive(1'b0, 2'b00, 3'd0, 7'd0, 1'b0);

        // flush in RUN cycle 2, then full-latency restart
        next_cycle(); drive(1'b1, 2'b10, 3'd1, 7'h01, 1'b0);
        next_cycle();
        next_cycle(); flush = 1'b1; mid();
        check("flush_run_stall", 32'(stall), 1);
        next_cycle(); drive(1'b0, 2'b00, 3'd0, 7'd0, 1'b0); mid();
        check("flush_busy", 32'(busy), 0);
        check("flush_stall", 32'(stall), 0);
        check("flush_done", 32'(done), 0);
        next_cycle(); drive(1'b1, 2'b10, 3'd0, 7'h01, 1'b0);
        dcyc = -1;
        for (int i = 0; i < 12; i++) begin
            mid();
            if (done && dcyc < 0) dcyc = i;
            next_cycle();
            if (i == 0) valid = 1'b0;
        end
        check("restart_done_cycle", 32'(dcyc), 32'(MUL_LAT));

        // reset mid-RUN
        drive(1'b1, 2'b10, 3'd3, 7'h01, 1'b0);
        next_cycle();
        next_cycle(); rst = 1'b1;
        next_cycle(); rst = 1'b0; drive(1'b0, 2'b00, 3'd0, 7'd0, 1'b0); mid();
        check("rstrun_busy", 32'(busy), 0);
        check("rstrun_stall", 32'(stall), 0);
        check("rstrun_done", 32'(done), 0);
        check("rstrun_op", 32'(mdu_op), 0);

        // back-to-back muls
        next_cycle(); drive(1'b1, 2'b10, 3'd2, 7'h01, 1'b0);
        s0 = -1; s1 = -1;
        for (cyc = 0; cyc < 16; cyc++) begin
            mid();
            if (mdu_start) begin
                if (s0 < 0) s0 = cyc;
                else if (s1 < 0) s1 = cyc;
            end
            next_cycle();
        end
        check("b2b_spacing", 32'(s1 - s0), 32'(MUL_LAT + 1));
        drive(1'b0, 2'b00, 3'd0, 7'd0, 1'b0);
        next_cycle();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [6:0] f7;
            case ($urandom_range(0, 3))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                2: f7 = 7'h01;
                default: f7 = 7'($urandom_range(0, 127));
            endcase
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)), f7, 1'($urandom_range(0, 9) == 0));
            rst = 1'($urandom_range(0, 79) == 0);
            next_cycle();
        end
        rst = 1'b0;
        mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
